sorted_stream_collector: RTL and testbench

Downstream stage of the binary sorter. It consumes the sorter's serial bit stream (out/VO) and reassembles each WIDTH-bit word into a parallel register offered over a valid/ready handshake. Alongside each word it reports the count of ones and a sortedness check (all ones precede all zeros). It also detects broken frames, through a gap timeout, and dropped words, through an overrun flag.

---
 rtl/sorted_stream_collector_if.sv | 30 +++
 rtl/sorted_stream_collector.sv | 121 ++++++++++++
 tb/tb_sorted_stream_collector.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sorted_stream_collector_if.sv
// Parallel word handshake between the serial collector and its consumer.
// The collector drives the word, its ones count and its sortedness flag.
// The consumer answers with word_ready.
interface sorted_stream_collector_if #(
    parameter int WIDTH = 8
) ();
    localparam int OW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready;
    logic [OW-1:0]    ones_cnt;
    logic             sorted;

    modport master (
        output word,
        output word_valid,
        output ones_cnt,
        output sorted,
        input  word_ready
    );

    modport slave (
        input  word,
        input  word_valid,
        input  ones_cnt,
        input  sorted,
        output word_ready
    );
endinterface

// File: rtl/sorted_stream_collector.sv
// Reassembles the sorter's serial bit stream into WIDTH-bit words.
// Each word is presented with its ones count and a sortedness check
// (all ones arrive before any zero).
// A partial word that stalls for TIMEOUT idle cycles is aborted with a frag_err pulse.
// A word that completes while the output register is still occupied sets a sticky overrun flag.
module sorted_stream_collector #(
    parameter int WIDTH     = 8,
    parameter int TIMEOUT   = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic ck,
    input  logic reset,
    input  logic si,
    input  logic vi,
    input  logic clr_err,
    output logic overrun,
    output logic frag_err,
    sorted_stream_collector_if.master result
);
    localparam int OW = $clog2(WIDTH + 1);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [GW-1:0]    gap_cnt, gap_cnt_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt, shift_in;
    logic [OW-1:0]    ones_run, ones_nxt, ones_in;
    logic             seen_zero, seen_zero_nxt;
    logic             unsorted, unsorted_nxt, unsorted_in;
    logic             complete, abort, load, drop;

    // Tracker next-state: shift in the current bit and detect completion or timeout.
    always_comb begin
        shift_in      = MSB_FIRST ? {shift_reg[WIDTH-2:0], si} : {si, shift_reg[WIDTH-1:1]};
        ones_in       = ones_run + OW'(si);
        unsorted_in   = unsorted | (si & seen_zero);
        complete      = vi && (bit_cnt == CW'(WIDTH - 1));
        abort         = !vi && (bit_cnt != '0) && (gap_cnt == GW'(TIMEOUT - 1));
        load          = complete && (!result.word_valid || result.word_ready);
        drop          = complete && !load;

        bit_cnt_nxt   = bit_cnt;
        gap_cnt_nxt   = gap_cnt;
        shift_nxt     = shift_reg;
        ones_nxt      = ones_run;
        seen_zero_nxt = seen_zero;
        unsorted_nxt  = unsorted;

        if (vi) begin
            gap_cnt_nxt = '0;
            if (complete) begin
                bit_cnt_nxt   = '0;
                shift_nxt     = '0;
                ones_nxt      = '0;
                seen_zero_nxt = 1'b0;
                unsorted_nxt  = 1'b0;
            end else begin
                bit_cnt_nxt   = bit_cnt + CW'(1);
                shift_nxt     = shift_in;
                ones_nxt      = ones_in;
                seen_zero_nxt = seen_zero | ~si;
                unsorted_nxt  = unsorted_in;
            end
        end else if (abort) begin
            bit_cnt_nxt   = '0;
            gap_cnt_nxt   = '0;
            shift_nxt     = '0;
            ones_nxt      = '0;
            seen_zero_nxt = 1'b0;
            unsorted_nxt  = 1'b0;
        end else if (bit_cnt != '0) begin
            gap_cnt_nxt = gap_cnt + GW'(1);
        end
    end

    // Tracker registers for the word currently being collected.
    always_ff @(posedge ck) begin
        if (reset) begin
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            shift_reg <= '0;
            ones_run  <= '0;
            seen_zero <= 1'b0;
            unsorted  <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            shift_reg <= shift_nxt;
            ones_run  <= ones_nxt;
            seen_zero <= seen_zero_nxt;
            unsorted  <= unsorted_nxt;
        end
    end

    // Output register and error flags; a new overrun wins over clr_err.
    always_ff @(posedge ck) begin
        if (reset) begin
            result.word       <= '0;
            result.word_valid <= 1'b0;
            result.ones_cnt   <= '0;
            result.sorted     <= 1'b0;
            overrun           <= 1'b0;
            frag_err          <= 1'b0;
        end else begin
            frag_err <= abort;
            if (load) begin
                result.word       <= shift_in;
                result.ones_cnt   <= ones_in;
                result.sorted     <= ~unsorted_in;
                result.word_valid <= 1'b1;
            end else if (result.word_valid && result.word_ready) begin
                result.word_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sorted_stream_collector.sv
// Directed bench for sorted_stream_collector (WIDTH=8, TIMEOUT=16, MSB first).
module tb_sorted_stream_collector;
    typedef struct {
        logic [7:0] bits;
        logic [7:0] exp_word;
        logic [3:0] exp_ones;
        logic       exp_sorted;
    } vec_t;

    logic ck = 1'b0;
    logic reset, si, vi, clr_err, overrun, frag_err;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   stream_on = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_word = '0;
    vec_t exp_q[$];
    vec_t vecs[7];
    vec_t stream_vecs[4];

    sorted_stream_collector_if #(.WIDTH(8)) result_bus ();

    sorted_stream_collector #(.WIDTH(8), .TIMEOUT(16), .MSB_FIRST(1'b1)) dut (
        .ck       (ck),
        .reset    (reset),
        .si       (si),
        .vi       (vi),
        .clr_err  (clr_err),
        .overrun  (overrun),
        .frag_err (frag_err),
        .result   (result_bus)
    );

    always #5 ck = ~ck;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
        cyc++;
        if (stream_on) result_bus.word_ready = cyc[1];
    endtask

    task automatic sendBit(input logic b);
        si = b;
        vi = 1'b1;
        tick();
        vi = 1'b0;
        si = 1'b0;
    endtask

    task automatic sendWord(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) sendBit(w[i]);
    endtask

    task automatic checkWord(input string tag, input vec_t v);
        checkOutput({tag, "_valid"}, result_bus.word_valid, 1);
        checkOutput({tag, "_word"}, result_bus.word, v.exp_word);
        checkOutput({tag, "_ones"}, result_bus.ones_cnt, v.exp_ones);
        checkOutput({tag, "_sorted"}, result_bus.sorted, v.exp_sorted);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        result_bus.word_ready = 1'b1;
        sendWord(v.bits);
        checkWord($sformatf("vec%0d", idx), v);
        checkOutput($sformatf("vec%0d_frag", idx), frag_err, 0);
        tick();
        checkOutput($sformatf("vec%0d_drop", idx), result_bus.word_valid, 0);
    endtask

    // Stream monitor: checks delivery order and stability of stalled words.
    always @(negedge ck) begin
        if (stream_on) begin
            if (prev_stall) begin
                checkOutput("stall_valid", result_bus.word_valid, 1);
                checkOutput("stall_word", result_bus.word, prev_word);
            end
            if (result_bus.word_valid && result_bus.word_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("stream_extra_word", result_bus.word, 32'hFFFF_FFFF);
                end else begin
                    checkWord("stream", exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = result_bus.word_valid && !result_bus.word_ready;
            prev_word  = result_bus.word;
        end
    end

    initial begin
        int pulses;

        vecs[0] = '{8'hF0, 8'hF0, 4'd4, 1'b1};
        vecs[1] = '{8'h55, 8'h55, 4'd4, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 4'd0, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 4'd8, 1'b1};
        vecs[4] = '{8'hE0, 8'hE0, 4'd3, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 4'd1, 1'b1};
        vecs[6] = '{8'h01, 8'h01, 4'd1, 1'b0};
        stream_vecs[0] = '{8'hC0, 8'hC0, 4'd2, 1'b1};
        stream_vecs[1] = '{8'h3C, 8'h3C, 4'd4, 1'b0};
        stream_vecs[2] = '{8'h55, 8'h55, 4'd4, 1'b0};
        stream_vecs[3] = '{8'h81, 8'h81, 4'd2, 1'b0};

        reset = 1'b1; si = 1'b0; vi = 1'b0; clr_err = 1'b0;
        result_bus.word_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_word", result_bus.word, 0);
        checkOutput("rst_valid", result_bus.word_valid, 0);
        checkOutput("rst_ones", result_bus.ones_cnt, 0);
        checkOutput("rst_sorted", result_bus.sorted, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_frag", frag_err, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

        // Overrun: second word completes while first is still held.
        result_bus.word_ready = 1'b0;
        sendWord(8'hF0);
        sendWord(8'hC0);
        checkWord("ovr_hold", vecs[0]);
        checkOutput("ovr_set", overrun, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("ovr_clr", overrun, 0);
        checkOutput("ovr_clr_word", result_bus.word, 8'hF0);
        result_bus.word_ready = 1'b1;
        tick();
        checkOutput("ovr_drain", result_bus.word_valid, 0);

        // Transfer on the completion edge of the second word.
        result_bus.word_ready = 1'b0;
        sendWord(8'hF0);
        for (int i = 7; i >= 1; i--) sendBit(stream_vecs[0].bits[i]);
        result_bus.word_ready = 1'b1;
        sendBit(stream_vecs[0].bits[0]);
        checkWord("swap", stream_vecs[0]);
        checkOutput("swap_overrun", overrun, 0);
        tick();
        checkOutput("swap_drain", result_bus.word_valid, 0);

        // Gap of 16 idle cycles aborts a 3-bit partial word.
        sendBit(1'b1); sendBit(1'b1); sendBit(1'b1);
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (frag_err) pulses++;
            if (result_bus.word_valid) pulses += 100;
        end
        checkOutput("frag_now", frag_err, 1);
        checkOutput("frag_pulses", pulses, 1);
        sendBit(1'b1);
        checkOutput("frag_one_cycle", frag_err, 0);
        for (int i = 6; i >= 0; i--) sendBit(vecs[4].bits[i]);
        checkWord("after_frag", vecs[4]);
        tick();

        // Gap of 15 idle cycles is tolerated.
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (frag_err) pulses++;
        end
        checkOutput("gap15_no_frag", pulses, 0);
        sendBit(1'b0); sendBit(1'b0); sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        checkWord("gap15", '{8'hA5, 8'hA5, 4'd4, 1'b0});
        tick();

        // Reset mid-word discards the partial word silently.
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_valid", result_bus.word_valid, 0);
        sendWord(8'hFF);
        checkWord("midrst", vecs[3]);
        checkOutput("midrst_frag", frag_err, 0);
        checkOutput("midrst_overrun", overrun, 0);
        tick();

        // Stream of four words with bit gaps and a toggling consumer.
        stream_on = 1'b1;
        for (int w = 0; w < 4; w++) begin
            exp_q.push_back(stream_vecs[w]);
            for (int b = 7; b >= 0; b--) begin
                sendBit(stream_vecs[w].bits[b]);
                if (b != 0) repeat ((w + b) % 4) tick();
            end
        end
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        checkOutput("stream_all_delivered", exp_q.size(), 0);
        checkOutput("stream_overrun", overrun, 0);
        stream_on = 1'b0;
        result_bus.word_ready = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
